// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 zero-tail convolutional encoder, optional CONV_ENC_PUNCT_EN rate-2/3 puncturing
package math_pkg;
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

module conv_encoder #(
  parameter int K = 7,
  parameter logic [K-1:0] G0 = 7'o171,
  parameter logic [K-1:0] G1 = 7'o133,
  localparam int CNT_W = math_pkg::log2(K)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] m_data,
  output logic       m_last,
  output logic [1:0] m_keep
);
  typedef enum logic {DATA, TAIL} state_t;
  state_t state, state_nxt;
  logic [K-2:0] sr;
  logic [CNT_W-1:0] tail_cnt, tail_cnt_nxt;
  logic slot_free, gen, bit_in, last_sym;
  logic [K-1:0] v;
  assign slot_free = !m_valid || m_ready;
  assign s_ready = rst_n && (state == DATA) && slot_free;
  assign gen = (state == DATA) ? (s_valid && s_ready) : slot_free;
  assign bit_in = (state == DATA) && s_data;
  assign v = {bit_in, sr};
  assign last_sym = (state == TAIL) && (tail_cnt == CNT_W'(1));
  // state and tail counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= DATA;
      tail_cnt <= '0;
    end else begin
      state <= state_nxt;
      tail_cnt <= tail_cnt_nxt;
    end
  // enter TAIL after the last info bit, return to DATA on the final flush symbol
  always_comb begin
    state_nxt = state;
    tail_cnt_nxt = tail_cnt;
    if (gen && state == DATA && s_last) begin
      state_nxt = TAIL;
      tail_cnt_nxt = CNT_W'(K - 1);
    end else if (gen && state == TAIL) begin
      tail_cnt_nxt = tail_cnt - CNT_W'(1);
      state_nxt = last_sym ? DATA : TAIL;
    end
  end
  // encoder shift register and single output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      m_valid <= 1'b0;
      m_data <= 2'b00;
      m_last <= 1'b0;
    end else if (gen) begin
      sr <= {bit_in, sr[K-2:1]};
      m_valid <= 1'b1;
      m_data <= {^(v & G1), ^(v & G0)};
      m_last <= last_sym;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
`ifdef CONV_ENC_PUNCT_EN
  logic phase;
  // puncture phase alternates per symbol and restarts with every frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= 1'b0;
      m_keep <= 2'b11;
    end else if (gen) begin
      m_keep <= phase ? 2'b01 : 2'b11;
      phase <= !last_sym && !phase;
    end
`else
  assign m_keep = 2'b11;
`endif
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed and model-checked tests of conv_encoder
module tb_conv_encoder;
  localparam int K = 7;
  localparam logic [6:0] G0 = 7'o171;
  localparam logic [6:0] G1 = 7'o133;
`ifdef CONV_ENC_PUNCT_EN
  localparam bit PUNCT = 1'b1;
`else
  localparam bit PUNCT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_data = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic s_ready, m_valid, m_last;
  logic [1:0] m_data, m_keep;
  typedef struct {logic [1:0] d; logic l; logic [1:0] k;} sym_t;
  sym_t rx[$], exp_q[$];
  sym_t imp[7];
  bit mb[$], tx_d[$], tx_l[$];
  int tests = 0, fails = 0;
  bit bp = 1'b0, hold = 1'b0;
  logic [4:0] hold_v;

  conv_encoder #(.K(K), .G0(G0), .G1(G1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_keep(m_keep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    sym_t s;
    if (rst_n) begin
      if (hold) chk("hold_stable", {26'd0, m_valid, m_data, m_last, m_keep}, {26'd0, 1'b1, hold_v});
      if (m_valid && m_ready) begin
        s.d = m_data; s.l = m_last; s.k = m_keep;
        rx.push_back(s);
      end
      hold = m_valid && !m_ready;
      hold_v = {m_data, m_last, m_keep};
    end else hold = 1'b0;
  end

  task automatic build_exp();
    int n;
    logic c0, c1;
    sym_t s;
    n = mb.size();
    for (int t = 0; t < n + K - 1; t++) begin
      c0 = 1'b0; c1 = 1'b0;
      for (int j = 0; j < K; j++)
        if (t - j >= 0 && t - j < n) begin
          c0 ^= G0[K-1-j] & mb[t-j];
          c1 ^= G1[K-1-j] & mb[t-j];
        end
      s.d = {c1, c0}; s.l = (t == n + K - 2); s.k = (PUNCT && (t % 2 == 1)) ? 2'b01 : 2'b11;
      exp_q.push_back(s);
    end
  endtask

  task automatic send();
    bit ok;
    int b;
    for (int i = 0; i < tx_d.size(); i++) begin
      ok = 1'b0; b = 0;
      s_valid = 1'b1; s_data = tx_d[i]; s_last = tx_l[i];
      while (!ok) begin
        @(negedge clk);
        ok = s_ready;
        @(posedge clk);
        #1;
        b++;
        if (!ok && b > 300) begin
          chk("send_timeout", 1, 0);
          s_valid = 1'b0; s_last = 1'b0;
          tx_d.delete(); tx_l.delete();
          return;
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    tx_d.delete(); tx_l.delete();
  endtask

  task automatic wait_rx(input string nm, input int n);
    int b;
    b = 0;
    while (rx.size() < n && b < 3000) begin
      @(posedge clk);
      b++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk(nm, rx.size(), n);
  endtask

  task automatic cmp_exp(input string nm);
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx.size()) begin
        chk({nm, "_data"}, rx[i].d, exp_q[i].d);
        chk({nm, "_last"}, rx[i].l, exp_q[i].l);
        chk({nm, "_keep"}, rx[i].k, exp_q[i].k);
      end
    rx.delete(); exp_q.delete(); mb.delete();
  endtask

  task automatic cmp_imp(input string nm);
    for (int i = 0; i < 7; i++)
      if (i < rx.size()) begin
        chk({nm, "_data"}, rx[i].d, imp[i].d);
        chk({nm, "_last"}, rx[i].l, imp[i].l);
        chk({nm, "_keep"}, rx[i].k, imp[i].k);
      end
  endtask

  initial begin
    int low, nl;
    imp = '{'{2'b11, 1'b0, 2'b11}, '{2'b01, 1'b0, 2'b11}, '{2'b11, 1'b0, 2'b11},
            '{2'b11, 1'b0, 2'b11}, '{2'b00, 1'b0, 2'b11}, '{2'b10, 1'b0, 2'b11},
            '{2'b11, 1'b1, 2'b11}};
    for (int i = 0; i < 7; i++) imp[i].k = (PUNCT && (i % 2 == 1)) ? 2'b01 : 2'b11;
    #3;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_keep", m_keep, 2'b11);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    // impulse frame against the hand-computed table and the model
    tx_d.push_back(1'b1); tx_l.push_back(1'b1);
    send();
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready) break;
      low++;
    end
    chk("imp_sready_low", low, 6);
    wait_rx("imp_count", 7);
    cmp_imp("imp");
    mb.push_back(1'b1);
    build_exp();
    cmp_exp("imp_model");
    // all-zero 20-bit frame
    for (int i = 0; i < 20; i++) begin
      tx_d.push_back(1'b0); tx_l.push_back(i == 19); mb.push_back(1'b0);
    end
    build_exp();
    send();
    wait_rx("zero_count", 26);
    nl = 0;
    foreach (rx[i]) if (rx[i].l) nl++;
    chk("zero_lastcnt", nl, 1);
    cmp_exp("zero");
    // random 100-bit frame under random backpressure
    bp = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bit b;
      b = 1'($urandom_range(0, 1));
      tx_d.push_back(b); tx_l.push_back(i == 99); mb.push_back(b);
    end
    build_exp();
    send();
    wait_rx("rand_count", 106);
    bp = 1'b0;
    cmp_exp("rand");
    // back-to-back 3-bit frames
    mb = '{1'b1, 1'b0, 1'b1};
    build_exp();
    mb = '{1'b1, 1'b1, 1'b0};
    build_exp();
    tx_d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tx_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    send();
    wait_rx("b2b_count", 18);
    cmp_exp("b2b");
    // reset pulsed while the third tail symbol is held
    tx_d.push_back(1'b1); tx_l.push_back(1'b1);
    send();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("midrst_rel_s_ready", s_ready, 1);
    rx.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_tail", rx.size(), 0);
    tx_d.push_back(1'b1); tx_l.push_back(1'b1);
    send();
    wait_rx("post_rst_count", 7);
    cmp_imp("post_rst");
    rx.delete();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
Rate-1/2 feedforward convolutional encoder with a zero-tail trellis termination. It is the transmit-side counterpart of the Fano sequential decoder and produces the coded symbol stream that the decoder consumes. Both ports use valid/ready streaming. The tail counter width comes from math_pkg::log2.

Parameters:
K, 7, constraint length; legal range 3..9.
G0, 7'o171, generator polynomial for code bit c0, K bits wide; the MSB taps the current input bit.
G1, 7'o133, generator polynomial for code bit c1, K bits wide; the MSB taps the current input bit.
CNT_W, math_pkg::log2(K), width of the tail counter (derived; do not override).

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input info bit valid
s_ready  out  1  encoder accepts an input bit this cycle
s_data  in  1  info bit
s_last  in  1  last info bit of the frame
m_valid  out  1  coded symbol valid
m_ready  in  1  downstream accepts the symbol
m_data  out  2  coded symbol {c1,c0}
m_last  out  1  final tail symbol of the frame
m_keep  out  2  per-bit validity of m_data

Behaviour:
- Reset (async assert, sync release): state=DATA, sr[K-2:0]=0, tail_cnt=0, m_valid=0, m_data=0, m_last=0, m_keep=2'b11.
  - s_ready=0 while rst_n is low.
  - s_ready=1 on the first cycle after release.
- Code bits: v={bit_in, sr}, c0=^(v&G0), c1=^(v&G1). After each symbol is generated, sr={bit_in, sr[K-2:1]}.
- Output stage is a single register. slot_free = !m_valid || m_ready.
- s_ready = (state==DATA) && slot_free. This is combinational from m_ready; there is no path from s_valid to s_ready.
- Accept (s_valid && s_ready): the symbol is registered next edge with m_valid=1. Latency is 1 cycle. Full throughput, 1 symbol/cycle, when m_ready=1.
- m_valid=1 && m_ready=0: m_data, m_last and m_keep hold stable and no new symbol is generated.
- The handshake completes and m_valid drops only when there is no new symbol that cycle.
- FSM:
  - DATA: on an accept with s_last=1, go to TAIL and set tail_cnt=K-1. The s_last symbol itself has m_last=0.
  - TAIL: s_ready=0. Each cycle with slot_free=1, generate a symbol with bit_in=0 and decrement tail_cnt. On the symbol generated with tail_cnt==1, set m_last=1 and go to DATA.
  - After exactly K-1 tail symbols sr is all-zero.
- Frame length is info_bits+K-1 symbols. A frame of 1 bit (s_last on the first bit) is legal.
- Back-to-back frames: a new frame's first bit can be accepted the cycle after the final tail symbol is generated, with no bubble beyond the slot_free rule.
- s_data and s_last are ignored when s_valid=0. s_last is ignored outside DATA because s_ready=0.
- Reset mid-frame or mid-tail: everything is cleared and no partial tail is emitted. The output register is dropped even if it was unacknowledged.

Optional Feature:
CONV_ENC_PUNCT_EN: rate-2/3 puncturing.
- Defined: a 1-bit phase toggles on every generated symbol, tail symbols included. Phase is cleared to 0 at reset and after each m_last symbol.
  - Phase 0: m_keep=2'b11.
  - Phase 1: m_keep=2'b01 (c1 is punctured; m_data[1] is still driven with c1).
- Not defined: m_keep is tied to 2'b11 and no phase register exists.
- Timing and handshake are identical in both builds.

Test Plan:
- Impulse, default params: s_data=1 with s_last=1, m_ready=1 → 7 symbols {c1,c0} = 11, 01, 11, 11, 00, 10, 11; m_last only on the 7th symbol; s_ready=0 for 6 cycles.
- All-zero frame of 20 bits with s_last on bit 20 → 26 symbols, all 00; exactly one m_last, on symbol 26.
- Random backpressure (m_ready 50% random) on a 100-bit random frame → symbol stream matches a reference model bit-exactly; m_data is stable while m_valid && !m_ready; no symbols lost or duplicated.
- Two back-to-back frames of 3 bits each (1,0,1 then 1,1,0) with continuous s_valid → 9+9 symbols; the second frame starts from sr=0 and matches an independently encoded frame.
- rst_n pulsed low during the 3rd tail symbol → m_valid=0 immediately; next frame impulse output equals test 1.
- With CONV_ENC_PUNCT_EN, impulse frame → m_keep sequence 11, 01, 11, 01, 11, 01, 11; the next frame starts at phase 0.
